// File: rtl/vm_wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and the round-robin winner search.
// Used by every file in the arbiter; pure declarations, no timing.
package vm_wb_pkg;
  localparam int WB_AW = 16;
  localparam int WB_DW = 16;
  localparam int WB_SW = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // First requester found searching upward from 'start', wrapping at nm.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start,
                                         input int nm);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = 2'((int'(start) + i) % nm);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction
endpackage

// File: rtl/vm_wb_wdog.sv
// Per-transfer watchdog: synthetic ack plus error pulse after TOUT strobe clocks with no ack.
// Same-clock combinational expiry; a real ack in the expiry clock suppresses it.
module vm_wb_wdog
  import vm_wb_pkg::*;
#(
  parameter int TOUT = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_i,
  input  logic ack_i,
  output logic wd_ack_o,
  output logic err_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    wd_ack_o = stb_i && !ack_i && (cnt_q == 8'(TOUT));
    err_o    = wd_ack_o;
    cnt_d    = cnt_q + 8'd1;
    if (!stb_i || ack_i || wd_ack_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vm_wb_arb.sv
// Wishbone shared-bus arbiter for up to four masters, whole-cycle grants, RR or fixed priority.
// Request-to-grant one clock; a forced idle clock separates owners; slave outputs are gated muxes.
module vm_wb_arb
  import vm_wb_pkg::*;
#(
  parameter int NM   = 4,
  parameter int RR   = 1,
  parameter int TOUT = 63
) (
  input  logic                  vm_clk_p,
  input  logic                  vm_rst_n,
  input  logic [NM-1:0]         wbm_cyc_i,
  input  logic [NM-1:0]         wbm_stb_i,
  input  logic [NM-1:0]         wbm_we_i,
  input  logic [WB_SW*NM-1:0]   wbm_sel_i,
  input  logic [WB_AW*NM-1:0]   wbm_adr_i,
  input  logic [WB_DW*NM-1:0]   wbm_dat_i,
  output logic [NM-1:0]         wbm_gnt_o,
  output logic [NM-1:0]         wbm_ack_o,
  output logic [WB_DW-1:0]      wbm_dat_o,
  output logic                  wbs_cyc_o,
  output logic                  wbs_stb_o,
  output logic                  wbs_we_o,
  output logic [WB_SW-1:0]      wbs_sel_o,
  output logic [WB_AW-1:0]      wbs_adr_o,
  output logic [WB_DW-1:0]      wbs_dat_o,
  input  logic [WB_DW-1:0]      wbs_dat_i,
  input  logic                  wbs_ack_i,
  output logic                  bus_err_o,
  output logic [1:0]            bus_own_o
);
  arb_state_e    state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [1:0]    own_q, own_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    req;
  logic [1:0]    win;
  logic          wd_ack;
  logic          wd_err;

  // ptr_q is where the next search starts, i.e. one past the last owner.
  always_comb begin
    req             = '0;
    req[NM-1:0]     = wbm_cyc_i;
    win             = rr_pick(req, (RR != 0) ? ptr_q : 2'd0, NM);
    state_d         = state_q;
    gnt_d           = gnt_q;
    own_d           = own_q;
    ptr_d           = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_BUSY;
          gnt_d   = NM'(1) << win;
          own_d   = win;
          ptr_d   = (int'(win) == NM - 1) ? 2'd0 : win + 2'd1;
        end
      end
      ARB_BUSY: begin
        if ((gnt_q & wbm_cyc_i) == '0) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grant is one-hot, so an AND-OR mux selects the owner and yields zero with no owner.
  always_comb begin
    wbs_cyc_o = |(gnt_q & wbm_cyc_i);
    wbs_stb_o = |(gnt_q & wbm_stb_i);
    wbs_we_o  = |(gnt_q & wbm_we_i);
    wbs_sel_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_q[k]) begin
        wbs_sel_o = wbs_sel_o | wbm_sel_i[WB_SW*k +: WB_SW];
        wbs_adr_o = wbs_adr_o | wbm_adr_i[WB_AW*k +: WB_AW];
        wbs_dat_o = wbs_dat_o | wbm_dat_i[WB_DW*k +: WB_DW];
      end
    end
  end

  vm_wb_wdog #(.TOUT(TOUT)) u_wdog (
    .clk      (vm_clk_p),
    .rst_n    (vm_rst_n),
    .stb_i    (wbs_stb_o),
    .ack_i    (wbs_ack_i),
    .wd_ack_o (wd_ack),
    .err_o    (wd_err)
  );

  assign wbm_gnt_o = gnt_q;
  assign wbm_ack_o = gnt_q & {NM{wbs_ack_i | wd_ack}};
  assign wbm_dat_o = wd_ack ? '0 : wbs_dat_i;
  assign bus_err_o = wd_err;
  assign bus_own_o = own_q;
endmodule

// File: tb/tb_vm_wb_arb.sv
// Directed scenarios plus randomized request rounds checked against a round-robin queue model.
module tb_vm_wb_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  m_cyc, m_stb, m_we;
  logic [1:0]  m_sel [4];
  logic [15:0] m_adr [4];
  logic [15:0] m_dat [4];
  logic [7:0]  sel_bus;
  logic [63:0] adr_bus, dat_bus;
  logic        s_ack;
  logic [15:0] s_dat;

  assign sel_bus = {m_sel[3], m_sel[2], m_sel[1], m_sel[0]};
  assign adr_bus = {m_adr[3], m_adr[2], m_adr[1], m_adr[0]};
  assign dat_bus = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};

  logic [3:0]  gnt_a, ack_a, gnt_b, ack_b;
  logic [15:0] rdat_a, rdat_b, adr_a, adr_b, wdat_a, wdat_b;
  logic        cyc_a, stb_a, we_a, err_a, cyc_b, stb_b, we_b, err_b;
  logic [1:0]  sel_a, sel_b, own_a, own_b;

  vm_wb_arb #(.NM(4), .RR(1), .TOUT(63)) u_dut (
    .vm_clk_p(clk), .vm_rst_n(rst_n),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_sel_i(sel_bus), .wbm_adr_i(adr_bus), .wbm_dat_i(dat_bus),
    .wbm_gnt_o(gnt_a), .wbm_ack_o(ack_a), .wbm_dat_o(rdat_a),
    .wbs_cyc_o(cyc_a), .wbs_stb_o(stb_a), .wbs_we_o(we_a),
    .wbs_sel_o(sel_a), .wbs_adr_o(adr_a), .wbs_dat_o(wdat_a),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack),
    .bus_err_o(err_a), .bus_own_o(own_a)
  );

  vm_wb_arb #(.NM(4), .RR(0), .TOUT(63)) u_dut_fp (
    .vm_clk_p(clk), .vm_rst_n(rst_n),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_sel_i(sel_bus), .wbm_adr_i(adr_bus), .wbm_dat_i(dat_bus),
    .wbm_gnt_o(gnt_b), .wbm_ack_o(ack_b), .wbm_dat_o(rdat_b),
    .wbs_cyc_o(cyc_b), .wbs_stb_o(stb_b), .wbs_we_o(we_b),
    .wbs_sel_o(sel_b), .wbs_adr_o(adr_b), .wbs_dat_o(wdat_b),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack),
    .bus_err_o(err_b), .bus_own_o(own_b)
  );

  int cmps = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_m(input int k, input logic we);
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    m_we[k]  = we;
    m_sel[k] = 2'($urandom);
    m_adr[k] = 16'($urandom);
    m_dat[k] = 16'($urandom);
  endtask

  task automatic drop_m(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  // Next owner: first pending master at or after the search pointer, wrapping over 4 slots.
  function automatic int model_pick(input logic [3:0] pend, input int ptr);
    for (int i = 0; i < 4; i++) if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
    return 0;
  endfunction

  task automatic wait_gnt(output int lat);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (gnt_a != 4'b0) break;
    end
  endtask

  // Called at the negedge where master k already owns the bus.
  task automatic serve_owned(input int k, input int delay, input bit rereq);
    logic [15:0] sd;
    chk("gnt", 32'(gnt_a), 32'(1 << k));
    chk("own", 32'(own_a), 32'(k));
    chk("s_cyc", 32'(cyc_a), 32'd1);
    chk("s_stb", 32'(stb_a), 32'd1);
    chk("s_we", 32'(we_a), 32'(m_we[k]));
    chk("s_sel", 32'(sel_a), 32'(m_sel[k]));
    chk("s_adr", 32'(adr_a), 32'(m_adr[k]));
    chk("s_wdat", 32'(wdat_a), 32'(m_dat[k]));
    for (int d = 0; d < delay; d++) begin
      chk("ack_early", 32'(ack_a), 32'd0);
      @(negedge clk);
    end
    sd    = 16'($urandom);
    s_dat = sd;
    s_ack = 1'b1;
    #1;
    chk("ack_route", 32'(ack_a), 32'(1 << k));
    chk("rdat", 32'(rdat_a), 32'(sd));
    chk("no_err", 32'(err_a), 32'd0);
    @(negedge clk);
    s_ack = 1'b0;
    drop_m(k);
    #1;
    chk("ack_one_clk", 32'(ack_a), 32'd0);
    @(negedge clk);
    chk("turnaround", 32'(gnt_a), 32'd0);
    if (rereq) req_m(k, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, early, mptr, exp_k;
    logic [3:0] pend;
    int order[6] = '{0, 2, 3, 0, 2, 3};
    bit rr_again[6] = '{1, 1, 1, 0, 0, 0};

    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_dat = '0;
    for (int k = 0; k < 4; k++) begin m_sel[k] = '0; m_adr[k] = '0; m_dat[k] = '0; end

    // Reset: a request held during reset must not leak through the mux.
    req_m(2, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_cyc", 32'(cyc_a), 32'd0);
    chk("rst_adr", 32'(adr_a), 32'd0);
    chk("rst_own", 32'(own_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    drop_m(2);
    rst_n = 1'b1;
    @(negedge clk);

    // Single master read.
    req_m(1, 1'b0);
    m_adr[1] = 16'o177714;
    #1;
    chk("pre_gnt", 32'(gnt_a), 32'd0);
    wait_gnt(lat);
    chk("single_lat", 32'(lat), 32'd1);
    serve_owned(1, 3, 1'b0);

    // Reset taken mid-transfer.
    req_m(1, 1'b0);
    wait_gnt(lat);
    chk("mid_gnt", 32'(gnt_a), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("rst_sync_hold", 32'(gnt_a), 32'b0010);
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt_a), 32'd0);
    chk("midrst_cyc", 32'(cyc_a), 32'd0);
    chk("midrst_ack", 32'(ack_a), 32'd0);
    chk("midrst_own", 32'(own_a), 32'd0);
    drop_m(1);
    s_ack = 1'b0;
    rst_n = 1'b1;

    // Round-robin contention among m0, m2, m3.
    req_m(0, 1'b0); req_m(2, 1'b1); req_m(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) m_cyc[2] = m_cyc[2];
      wait_gnt(lat);
      chk("rr_order", 32'(gnt_a), 32'(1 << order[i]));
      if (i >= 3) drop_m(order[i] == 0 ? 2 : 9 - 9 + order[i] == 2 ? 0 : 0);
      serve_owned(order[i], 1, rr_again[i]);
      if (i == 3) begin drop_m(2); req_m(2, 1'b0); end
    end

    // Watchdog expiry on an unmapped write.
    req_m(0, 1'b1);
    m_adr[0] = 16'o160000;
    s_dat = 16'hBEEF;
    wait_gnt(lat);
    chk("wd_gnt", 32'(gnt_a), 32'b0001);
    early = 0;
    for (int i = 0; i < 63; i++) begin
      if (ack_a != 4'b0 || err_a != 1'b0) early++;
      @(negedge clk);
    end
    chk("wd_early", 32'(early), 32'd0);
    chk("wd_ack", 32'(ack_a), 32'b0001);
    chk("wd_err", 32'(err_a), 32'd1);
    chk("wd_dat", 32'(rdat_a), 32'd0);
    @(negedge clk);
    chk("wd_err_pulse", 32'(err_a), 32'd0);
    chk("wd_ack_pulse", 32'(ack_a), 32'd0);
    drop_m(0);
    @(negedge clk);
    chk("wd_idle", 32'(gnt_a), 32'd0);

    // Real ack on the expiry clock wins.
    req_m(0, 1'b0);
    wait_gnt(lat);
    early = 0;
    for (int i = 0; i < 63; i++) begin
      if (ack_a != 4'b0 || err_a != 1'b0) early++;
      @(negedge clk);
    end
    chk("tie_early", 32'(early), 32'd0);
    s_dat = 16'h5A3C;
    s_ack = 1'b1;
    #1;
    chk("tie_ack", 32'(ack_a), 32'b0001);
    chk("tie_err", 32'(err_a), 32'd0);
    chk("tie_dat", 32'(rdat_a), 32'h5A3C);
    @(negedge clk);
    s_ack = 1'b0;
    drop_m(0);
    @(negedge clk);
    chk("tie_idle", 32'(gnt_a), 32'd0);

    // Random request rounds against the queue model; pointer is one past the last owner (m0).
    mptr = 1;
    for (int r = 0; r < 14; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) if (pend[k]) req_m(k, 1'($urandom_range(0, 1)));
      for (int j = 0; j < 4; j++) begin
        if (pend != 4'b0) begin
          exp_k = model_pick(pend, mptr);
          wait_gnt(lat);
          serve_owned(exp_k, int'($urandom_range(0, 3)), 1'b0);
          pend[exp_k] = 1'b0;
          mptr = (exp_k + 1) % 4;
        end
      end
    end

    // Fixed priority: no preemption, then lowest index wins every idle slot.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_m(3, 1'b0);
    @(negedge clk);
    chk("fp_gnt3", 32'(gnt_b), 32'b1000);
    chk("fp_adr3", 32'(adr_b), 32'(m_adr[3]));
    @(negedge clk);
    req_m(0, 1'b0);
    req_m(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fp_hold", 32'(gnt_b), 32'b1000);
    end
    drop_m(3);
    @(negedge clk);
    chk("fp_turn", 32'(gnt_b), 32'd0);
    @(negedge clk);
    chk("fp_gnt0", 32'(gnt_b), 32'b0001);
    s_dat = 16'h1234;
    s_ack = 1'b1;
    #1;
    chk("fp_ack0", 32'(ack_b), 32'b0001);
    chk("fp_dat0", 32'(rdat_b), 32'h1234);
    @(negedge clk);
    s_ack = 1'b0;
    drop_m(0);
    @(negedge clk);
    chk("fp_turn2", 32'(gnt_b), 32'd0);
    req_m(0, 1'b0);
    @(negedge clk);
    chk("fp_gnt0_again", 32'(gnt_b), 32'b0001);
    drop_m(0);
    @(negedge clk);
    chk("fp_turn3", 32'(gnt_b), 32'd0);
    @(negedge clk);
    chk("fp_gnt2", 32'(gnt_b), 32'b0100);
    drop_m(2);
    repeat (2) @(negedge clk);
    chk("fp_end_idle", 32'(gnt_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/vm_wb_arb.md
Name: vm_wb_arb

Overview:
- Shared-bus arbiter sitting between up to four Wishbone bus masters and the single system Wishbone slave bus.
- Masters are the VM3 processor thunk, the DMA/disk controller, the host debug port and a spare slot.
- Grants whole bus cycles. Priority is round-robin or fixed.
- A per-transfer watchdog terminates hung accesses to unmapped addresses with a synthetic ack and an error flag.

Parameters:
- NM, 4: number of masters (2..4); requests above NM-1 are ignored.
- RR, 1: 1 selects round-robin; 0 selects fixed priority where master 0 is highest.
- TOUT, 63: watchdog limit in clocks of stb without ack (1..255).

Ports:
- vm_clk_p  in  1  system clock; all logic on rising edge.
- vm_rst_n  in  1  reset, synchronous, active-low.
- wbm_cyc_i  in  NM  per-master cycle request.
- wbm_stb_i  in  NM  per-master strobe.
- wbm_we_i  in  NM  per-master write enable.
- wbm_sel_i  in  2*NM  byte selects, master k at [2k+1:2k].
- wbm_adr_i  in  16*NM  addresses, master k at [16k+15:16k].
- wbm_dat_i  in  16*NM  write data, master k at [16k+15:16k].
- wbm_gnt_o  out  NM  one-hot grant.
- wbm_ack_o  out  NM  ack routed to the owner only.
- wbm_dat_o  out  16  read data broadcast to all masters.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  slave control.
- wbs_sel_o  out  2  slave byte selects.
- wbs_adr_o  out  16  slave address.
- wbs_dat_o  out  16  slave write data.
- wbs_dat_i  in  16  slave read data.
- wbs_ack_i  in  1  slave ack.
- bus_err_o  out  1  one-clock pulse on watchdog expiry.
- bus_own_o  out  2  index of current/last owner, for debug.

Behaviour:
- Reset (vm_rst_n=0 at clock edge): state IDLE, gnt=0, every wbs_* output 0, wbm_ack_o=0, bus_err_o=0, watchdog counter 0, bus_own_o=0, RR pointer=0. Reset taken mid-cycle drops the grant immediately; the master sees cyc aborted.
- States: IDLE and BUSY.
- IDLE:
  - Any wbm_cyc_i[k]=1 selects a winner. RR=1: first requester searching upward from (last owner+1) mod NM. RR=0: lowest index.
  - Next clock: state BUSY, gnt one-hot for the winner, bus_own_o=winner.
  - Latency from request to grant is 1 clock.
- BUSY:
  - wbs_cyc/stb/we/sel/adr/dat are combinational muxes of the owner's inputs, gated by gnt. With no owner they are 0.
  - wbm_ack_o[owner] = wbs_ack_i | wd_ack. All other acks are 0.
  - wbm_dat_o = wd_ack ? 0 : wbs_dat_i.
  - Grant is held for the owner's entire cyc, including multiple stb phases; no preemption.
  - Owner drops cyc: next clock returns to IDLE, gnt=0. This gives one mandatory idle turnaround clock, so back-to-back owners are never adjacent.
  - Re-arbitration happens in IDLE. With RR=1 the previous owner has lowest priority.
- Watchdog:
  - 8-bit counter, clears when stb is low or when ack is seen, increments while owner stb=1 & wbs_ack_i=0.
  - When counter==TOUT and no ack: wd_ack=1 for exactly one clock, bus_err_o pulses, counter clears.
  - The slave cycle is not withdrawn by the arbiter; the master terminates it.
  - A late wbs_ack_i on the following clock is passed through unchanged. The master is responsible for ignoring it.
- Simultaneous events:
  - wbs_ack_i and watchdog expiry in the same clock: the real ack wins, no error.
  - Owner drops cyc in the same clock another master requests: grant is issued 2 clocks later (BUSY->IDLE->BUSY).
  - Request withdrawn while IDLE before the grant edge: it is not granted, because the winner is evaluated on the current clock only.
- Masters with index ≥ NM: outputs tied 0.

Decomposition:
- Shared package vm_wb_pkg holds:
  - Constants WB_AW=16, WB_DW=16, WB_SW=2.
  - State encoding ARB_IDLE=1'b0, ARB_BUSY=1'b1.
  - Function rr_pick(req, last, nm) returning the winner index.
- One natural sub-module: vm_wb_wdog, the watchdog counter. It takes stb, ack and TOUT and outputs wd_ack/err.
- The mux and FSM stay in vm_wb_arb.

Test Plan:
- Single master: m1 cyc/stb read at adr 0o177714 with slave ack after 3 clocks, data 0o123456 -> gnt=0010 one clock after cyc; wbm_ack_o=0010 for one clock; wbm_dat_o=0o123456; IDLE one clock after cyc drop.
- Contention with RR=1: m0, m2 and m3 all request continuously, each doing one-word cycles -> grant order 0,2,3,0,2,3. Each grant is separated by one clock with gnt=0000.
- Fixed priority with RR=0: m3 is busy and m0 requests mid-cycle -> m3 keeps the grant until its cyc drops; m0 is granted 2 clocks after the drop.
- Watchdog with TOUT=63: m0 write to an unmapped address with no slave ack -> exactly 63 clocks of stb, then wbm_ack_o[0] and bus_err_o pulse one clock, wbm_dat_o=0.
- Tie case: slave ack arrives on the same clock the counter reaches TOUT -> ack delivered, bus_err_o stays 0.
- Reset mid-transfer: vm_rst_n=0 while m1 is in BUSY with stb high -> on the next edge gnt=0, wbs_cyc_o=0, wbm_ack_o=0. After release, the first request is granted under RR pointer 0.
